// File: rtl/oam_dma_ctrl.sv
// NES sprite DMA ($4014) controller and CPU/DMA bus arbiter in the CPU clock domain.
// Define OAM_DMA_ALIGN_EN to insert the 2A03 alignment cycle (513/514-cycle DMA).
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr_i,
    input  logic        cpu_rw_i,
    input  logic [7:0]  cpu_data_i,
    input  logic [7:0]  bus_data_i,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr_o,
    output logic        bus_rw_o,
    output logic [7:0]  bus_data_o,
    output logic        dma_active,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] latch_q, latch_d;
    logic       parity_q, parity_d;
    logic       cpu_rdy_q, cpu_rdy_d;
    logic       dma_active_q, dma_active_d;
    logic       dma_done_q, dma_done_d;

    // Next-state logic for the transfer sequencer and its status flags.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        latch_d  = latch_q;
        parity_d = ~parity_q;
        case (state_q)
            S_IDLE: begin
                if (!cpu_rw_i && (cpu_addr_i == DMA_REG_ADDR)) begin
                    page_d  = cpu_data_i;
                    state_d = S_HALT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                // The 6502 ignores RDY on writes, so wait for its first read cycle.
                if (cpu_rw_i) begin
`ifdef OAM_DMA_ALIGN_EN
                    state_d = (parity_q == 1'b0) ? S_ALIGN : S_READ;
`else
                    state_d = S_READ;
`endif
                end else begin
                    state_d = S_HALT;
                end
            end
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                latch_d = bus_data_i;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = 8'h00;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cpu_rdy_d    = (state_d == S_IDLE);
        dma_active_d = (state_d == S_ALIGN) || (state_d == S_READ) || (state_d == S_WRITE);
        dma_done_d   = (state_d == S_WRITE) && (idx_d == LAST_IDX);
    end

    // State and output registers; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            page_q       <= 8'h00;
            idx_q        <= 8'h00;
            latch_q      <= 8'h00;
            parity_q     <= 1'b0;
            cpu_rdy_q    <= 1'b1;
            dma_active_q <= 1'b0;
            dma_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            idx_q        <= idx_d;
            latch_q      <= latch_d;
            parity_q     <= parity_d;
            cpu_rdy_q    <= cpu_rdy_d;
            dma_active_q <= dma_active_d;
            dma_done_q   <= dma_done_d;
        end
    end

    // Bus arbitration: the CPU passes through unless DMA owns the cycle.
    always_comb begin
        bus_addr_o = cpu_addr_i;
        bus_rw_o   = cpu_rw_i;
        bus_data_o = cpu_data_i;
        case (state_q)
            S_IDLE, S_HALT: begin
                bus_addr_o = cpu_addr_i;
                bus_rw_o   = cpu_rw_i;
            end
            S_ALIGN: bus_rw_o = 1'b1;
            S_READ: begin
                bus_addr_o = {page_q, idx_q};
                bus_rw_o   = 1'b1;
            end
            S_WRITE: begin
                bus_addr_o = OAM_DATA_ADDR;
                bus_rw_o   = 1'b0;
                bus_data_o = latch_q;
            end
            default: begin
                bus_addr_o = cpu_addr_i;
                bus_rw_o   = cpu_rw_i;
            end
        endcase
    end

    assign cpu_rdy    = cpu_rdy_q;
    assign dma_active = dma_active_q;
    assign dma_done   = dma_done_q;

endmodule
